// File: rtl/control_state_output.sv
// State register and control-signal decoder for the multi-cycle CPU control unit.
// Also keeps a sticky halt flag and a count of retired instructions (PCWre pulses).
module control_state_output #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [2:0]       n_state,
  input  logic [5:0]       Opcode,
  input  logic             zero,
  input  logic             sign,
  output logic [2:0]       cur_state,
  output logic             PCWre,
  output logic             IRWre,
  output logic             InsMemRW,
  output logic             ExtSel,
  output logic [1:0]       RegDst,
  output logic             RegWre,
  output logic             WrRegDSrc,
  output logic             DBDataSrc,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             mRD,
  output logic             mWR,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] ST_IF  = 3'b000;
  localparam logic [2:0] ST_ID  = 3'b001;
  localparam logic [2:0] ST_EXE = 3'b010;
  localparam logic [2:0] ST_WB  = 3'b011;
  localparam logic [2:0] ST_MEM = 3'b100;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SLTI = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_BGTZ = 6'b110110;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic is_add, is_sub, is_addi, is_or, is_and, is_ori, is_sll, is_slt, is_slti;
  logic is_sw, is_lw, is_beq, is_bne, is_bgtz, is_j, is_jr, is_jal, is_halt;
  logic is_ralu, is_branch, legal_op, legal_st, active, taken, final_st;

  assign is_add  = (Opcode == OP_ADD);
  assign is_sub  = (Opcode == OP_SUB);
  assign is_addi = (Opcode == OP_ADDI);
  assign is_or   = (Opcode == OP_OR);
  assign is_and  = (Opcode == OP_AND);
  assign is_ori  = (Opcode == OP_ORI);
  assign is_sll  = (Opcode == OP_SLL);
  assign is_slt  = (Opcode == OP_SLT);
  assign is_slti = (Opcode == OP_SLTI);
  assign is_sw   = (Opcode == OP_SW);
  assign is_lw   = (Opcode == OP_LW);
  assign is_beq  = (Opcode == OP_BEQ);
  assign is_bne  = (Opcode == OP_BNE);
  assign is_bgtz = (Opcode == OP_BGTZ);
  assign is_j    = (Opcode == OP_J);
  assign is_jr   = (Opcode == OP_JR);
  assign is_jal  = (Opcode == OP_JAL);
  assign is_halt = (Opcode == OP_HALT);

  assign is_ralu   = is_add | is_sub | is_or | is_and | is_sll | is_slt;
  assign is_branch = is_beq | is_bne | is_bgtz;
  assign legal_op  = is_ralu | is_addi | is_ori | is_slti | is_sw | is_lw | is_branch |
                     is_j | is_jr | is_jal | is_halt;
  assign legal_st  = (cur_state <= ST_MEM);
  assign active    = legal_op & legal_st;
  assign taken     = (is_beq & zero) | (is_bne & ~zero) | (is_bgtz & ~zero & ~sign);

  // Last state of each instruction class; PC is written there.
  always_comb begin
    final_st = (cur_state == ST_WB);
    if (is_j | is_jr)   final_st = (cur_state == ST_ID);
    else if (is_branch) final_st = (cur_state == ST_EXE);
    else if (is_sw)     final_st = (cur_state == ST_MEM);
  end

  assign InsMemRW = 1'b1;

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    ExtSel    = 1'b0;
    RegDst    = 2'b00;
    RegWre    = 1'b0;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = 3'b000;
    PCSrc     = 2'b00;
    mRD       = 1'b0;
    mWR       = 1'b0;
    if (active) begin
      // Write enables are gated by Reset so a mid-instruction reset cannot commit anything.
      PCWre     = Reset & ~halted & ~is_halt & final_st;
      IRWre     = Reset & ~halted & (cur_state == ST_IF);
      RegWre    = Reset & (cur_state == ST_WB) &
                  (is_ralu | is_addi | is_ori | is_slti | is_lw | is_jal);
      mRD       = Reset & (cur_state == ST_MEM) & is_lw;
      mWR       = Reset & (cur_state == ST_MEM) & is_sw;
      ExtSel    = ~is_ori;
      ALUSrcA   = is_sll;
      ALUSrcB   = is_addi | is_ori | is_slti | is_lw | is_sw;
      WrRegDSrc = ~is_jal;
      DBDataSrc = is_lw;
      if (is_ralu)     RegDst = 2'b01;
      else if (is_jal) RegDst = 2'b10;
      if (is_sub | is_branch)   ALUOp = 3'b001;
      else if (is_sll)          ALUOp = 3'b010;
      else if (is_or | is_ori)  ALUOp = 3'b011;
      else if (is_and)          ALUOp = 3'b100;
      else if (is_slt | is_slti) ALUOp = 3'b101;
      if (is_j | is_jal)                      PCSrc = 2'b11;
      else if (is_jr)                         PCSrc = 2'b10;
      else if (taken && cur_state == ST_EXE)  PCSrc = 2'b01;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cur_state   <= ST_IF;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      cur_state <= n_state;
      if (cur_state == ST_ID && is_halt) halted <= 1'b1;
      if (PCWre) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_control_state_output.sv
// Randomised and directed bench for control_state_output against a table-level reference model.
module tb_control_state_output;

  localparam int unsigned CW = 4;

  typedef struct packed {
    logic       pcwre;
    logic       irwre;
    logic       insmem;
    logic       extsel;
    logic [1:0] regdst;
    logic       regwre;
    logic       wrsrc;
    logic       dbsrc;
    logic       srca;
    logic       srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       mrd;
    logic       mwr;
  } ctrl_t;

  logic          CLK = 1'b0;
  logic          Reset = 1'b0;
  logic [2:0]    n_state = 3'd0;
  logic [5:0]    Opcode = 6'd0;
  logic          zero = 1'b0;
  logic          sign = 1'b0;
  logic [2:0]    cur_state;
  logic          PCWre, IRWre, InsMemRW, ExtSel, RegWre, WrRegDSrc, DBDataSrc;
  logic          ALUSrcA, ALUSrcB, mRD, mWR, halted;
  logic [1:0]    RegDst, PCSrc;
  logic [2:0]    ALUOp;
  logic [CW-1:0] instr_count;
  ctrl_t         obs;

  control_state_output #(.CNT_W(CW)) dut (
    .CLK(CLK), .Reset(Reset), .n_state(n_state), .Opcode(Opcode), .zero(zero), .sign(sign),
    .cur_state(cur_state), .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
    .ExtSel(ExtSel), .RegDst(RegDst), .RegWre(RegWre), .WrRegDSrc(WrRegDSrc),
    .DBDataSrc(DBDataSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .mRD(mRD), .mWR(mWR), .halted(halted), .instr_count(instr_count)
  );

  assign obs = {PCWre, IRWre, InsMemRW, ExtSel, RegDst, RegWre, WrRegDSrc, DBDataSrc,
                ALUSrcA, ALUSrcB, ALUOp, PCSrc, mRD, mWR};

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;
  logic [2:0]    m_st = 3'd0;
  logic          m_halt = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  ctrl_t         exp_c;

  logic [5:0] ops [18] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
                           6'b011000, 6'b100110, 6'b100111, 6'b110000, 6'b110001, 6'b110100,
                           6'b110101, 6'b110110, 6'b111000, 6'b111001, 6'b111010, 6'b111111};

  function automatic string op_name(input logic [5:0] op);
    case (op)
      6'b000000: return "add";   6'b000001: return "sub";   6'b000010: return "addi";
      6'b010000: return "or";    6'b010001: return "and";   6'b010010: return "ori";
      6'b011000: return "sll";   6'b100110: return "slt";   6'b100111: return "slti";
      6'b110000: return "sw";    6'b110001: return "lw";    6'b110100: return "beq";
      6'b110101: return "bne";   6'b110110: return "bgtz";  6'b111000: return "j";
      6'b111001: return "jr";    6'b111010: return "jal";   6'b111111: return "halt";
      default:   return "";
    endcase
  endfunction

  // Reference: states named IF=0 ID=1 EXE=2 WB=3 MEM=4.
  function automatic ctrl_t model(input logic [2:0] st, input logic [5:0] op, input logic z,
                                  input logic s, input logic h, input logic rst);
    ctrl_t c;
    string nm;
    int    last;
    logic  rtype, tk;
    c = '0;
    c.insmem = 1'b1;
    nm = op_name(op);
    if (nm == "" || st > 3'd4) return c;
    rtype = (nm == "add" || nm == "sub" || nm == "or" || nm == "and" || nm == "sll" ||
             nm == "slt");
    if (nm == "j" || nm == "jr") last = 1;
    else if (nm == "beq" || nm == "bne" || nm == "bgtz") last = 2;
    else if (nm == "sw") last = 4;
    else last = 3;
    tk = (nm == "beq" && z) || (nm == "bne" && !z) || (nm == "bgtz" && !z && !s);
    c.pcwre  = rst && !h && nm != "halt" && int'(st) == last;
    c.irwre  = rst && !h && st == 3'd0;
    c.extsel = (nm != "ori");
    c.srca   = (nm == "sll");
    c.srcb   = (nm == "addi" || nm == "ori" || nm == "slti" || nm == "lw" || nm == "sw");
    if (nm == "sub" || nm == "beq" || nm == "bne" || nm == "bgtz") c.aluop = 3'd1;
    else if (nm == "sll") c.aluop = 3'd2;
    else if (nm == "or" || nm == "ori") c.aluop = 3'd3;
    else if (nm == "and") c.aluop = 3'd4;
    else if (nm == "slt" || nm == "slti") c.aluop = 3'd5;
    if (nm == "j" || nm == "jal") c.pcsrc = 2'd3;
    else if (nm == "jr") c.pcsrc = 2'd2;
    else if (tk && st == 3'd2) c.pcsrc = 2'd1;
    c.mrd    = rst && st == 3'd4 && nm == "lw";
    c.mwr    = rst && st == 3'd4 && nm == "sw";
    c.regwre = rst && st == 3'd3 && (rtype || nm == "addi" || nm == "ori" || nm == "slti" ||
                                     nm == "lw" || nm == "jal");
    c.regdst = rtype ? 2'd1 : (nm == "jal") ? 2'd2 : 2'd0;
    c.wrsrc  = (nm != "jal");
    c.dbsrc  = (nm == "lw");
    return c;
  endfunction

  task automatic check(input string tag);
    exp_c = model(m_st, Opcode, zero, sign, m_halt, Reset);
    n_cmp++;
    assert (obs === exp_c) else begin
      n_fail++;
      $error("FAIL %s/ctrl: observed %h expected %h", tag, obs, exp_c);
    end
    n_cmp++;
    assert (cur_state === m_st) else begin
      n_fail++;
      $error("FAIL %s/state: observed %0d expected %0d", tag, cur_state, m_st);
    end
    n_cmp++;
    assert (halted === m_halt) else begin
      n_fail++;
      $error("FAIL %s/halted: observed %b expected %b", tag, halted, m_halt);
    end
    n_cmp++;
    assert (instr_count === m_cnt) else begin
      n_fail++;
      $error("FAIL %s/count: observed %0d expected %0d", tag, instr_count, m_cnt);
    end
  endtask

  // Entered and left at a negedge with Reset high.
  task automatic step(input logic [2:0] ns, input logic [5:0] op, input logic z,
                      input logic s, input string tag);
    n_state = ns;
    Opcode  = op;
    zero    = z;
    sign    = s;
    #1;
    check(tag);
    @(posedge CLK);
    if (exp_c.pcwre) m_cnt = m_cnt + 1'b1;
    if (m_st == 3'd1 && op == 6'b111111) m_halt = 1'b1;
    m_st = ns;
    @(negedge CLK);
  endtask

  task automatic async_reset(input string tag);
    #2 Reset = 1'b0;
    m_st = 3'd0;
    m_halt = 1'b0;
    m_cnt = '0;
    #1;
    check(tag);
    @(posedge CLK);
    #1;
    check({tag, "_held"});
    n_state = 3'd0;
    @(negedge CLK);
    Reset = 1'b1;
  endtask

  initial begin
    logic [5:0] op;
    #1;
    check("por");
    @(negedge CLK);
    Reset = 1'b1;

    // add: IF ID EXE WB
    step(3'd1, 6'b000000, 1'b0, 1'b0, "add_if");
    step(3'd2, 6'b000000, 1'b0, 1'b0, "add_id");
    step(3'd3, 6'b000000, 1'b0, 1'b0, "add_exe");
    step(3'd0, 6'b000000, 1'b0, 1'b0, "add_wb");
    // lw: IF ID EXE MEM WB; sw: IF ID EXE MEM
    step(3'd1, 6'b110001, 1'b0, 1'b0, "lw_if");
    step(3'd2, 6'b110001, 1'b0, 1'b0, "lw_id");
    step(3'd4, 6'b110001, 1'b0, 1'b0, "lw_exe");
    step(3'd3, 6'b110001, 1'b0, 1'b0, "lw_mem");
    step(3'd0, 6'b110001, 1'b0, 1'b0, "lw_wb");
    step(3'd1, 6'b110000, 1'b0, 1'b0, "sw_if");
    step(3'd2, 6'b110000, 1'b0, 1'b0, "sw_id");
    step(3'd4, 6'b110000, 1'b0, 1'b0, "sw_exe");
    step(3'd0, 6'b110000, 1'b0, 1'b0, "sw_mem");
    // reset in the middle of an add's EXE
    step(3'd1, 6'b000000, 1'b0, 1'b0, "add2_if");
    step(3'd2, 6'b000000, 1'b0, 1'b0, "add2_id");
    n_state = 3'd3;
    async_reset("rst_mid_exe");
    // branches
    step(3'd1, 6'b110100, 1'b1, 1'b0, "beq_t_if");
    step(3'd2, 6'b110100, 1'b1, 1'b0, "beq_t_id");
    step(3'd0, 6'b110100, 1'b1, 1'b0, "beq_t_exe");
    step(3'd1, 6'b110100, 1'b0, 1'b0, "beq_n_if");
    step(3'd2, 6'b110100, 1'b0, 1'b0, "beq_n_id");
    step(3'd0, 6'b110100, 1'b0, 1'b0, "beq_n_exe");
    step(3'd1, 6'b110110, 1'b0, 1'b1, "bgtz_if");
    step(3'd2, 6'b110110, 1'b0, 1'b1, "bgtz_id");
    step(3'd0, 6'b110110, 1'b0, 1'b1, "bgtz_exe");
    // jal: IF ID WB; jr: IF ID
    step(3'd1, 6'b111010, 1'b0, 1'b0, "jal_if");
    step(3'd3, 6'b111010, 1'b0, 1'b0, "jal_id");
    step(3'd0, 6'b111010, 1'b0, 1'b0, "jal_wb");
    step(3'd1, 6'b111001, 1'b0, 1'b0, "jr_if");
    step(3'd0, 6'b111001, 1'b0, 1'b0, "jr_id");
    // halt, then 20 cycles of arbitrary activity
    step(3'd1, 6'b111111, 1'b0, 1'b0, "halt_if");
    step(3'd2, 6'b111111, 1'b0, 1'b0, "halt_id");
    for (int i = 0; i < 20; i++) begin
      op = ops[$urandom_range(0, 16)];
      step(3'($urandom_range(0, 4)), op, 1'($urandom), 1'($urandom), "halted_run");
    end
    async_reset("rst_after_halt");

    // random phase: legal and illegal states/opcodes, occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 17)];
      if ($urandom_range(0, 40) == 0) async_reset("rand_rst");
      else step(3'($urandom_range(0, 7)), op, 1'($urandom), 1'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
